// File: rtl/platform_onchip_ram_pipelined_if.sv
// Avalon-MM pipelined slave bus for the on-chip RAM: command, write data and
// the read-return / flow-control signals.
interface platform_onchip_ram_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
);
  logic                    chipselect;
  logic [ADDR_WIDTH-1:0]   address;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output chipselect, address, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  chipselect, address, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/platform_onchip_ram_pipelined.sv
// Single-port on-chip RAM with Avalon-MM pipelined slave, 1- or 2-cycle read
// latency, and an optional post-reset sweep that fills the array with INIT_VALUE.
module platform_onchip_ram_pipelined #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 15,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             reset_req,
  input  logic                             clken,
  platform_onchip_ram_pipelined_if.slave   avs,
  output logic                             init_busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   ctr_q;
  logic                    stall;
  logic                    accept, wr_acc, rd_acc;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [NB-1:0]           mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    s1_v_q;
  logic [DATA_WIDTH-1:0]   s1_d_q;
  logic                    out_v;
  logic [DATA_WIDTH-1:0]   out_d;

  assign stall           = reset_req | ~clken;
  assign init_busy       = (state_q == ST_CLEAR);
  assign avs.waitrequest = (state_q != ST_READY) | stall;
  assign accept          = avs.chipselect & ~avs.waitrequest & (avs.read | avs.write);
  assign wr_acc          = accept & avs.write;
  assign rd_acc          = accept & avs.read & ~avs.write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      ctr_q   <= '0;
    end else if (!stall) begin
      case (state_q)
        ST_CLEAR: begin
          ctr_q <= ctr_q + 1'b1;
          if (ctr_q == '1) state_q <= ST_READY;
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

  // The clear sweep and bus writes share the single write port.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = avs.address;
    mem_be    = avs.byteenable;
    mem_wdata = avs.writedata;
    if (state_q == ST_CLEAR) begin
      mem_we    = ~stall;
      mem_addr  = ctr_q;
      mem_be    = '1;
      mem_wdata = INIT_VALUE;
    end else begin
      mem_we    = wr_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Array is read combinationally in the accept cycle, so a write committed at
  // the previous edge is already visible to the following read.
  assign rd_word = mem[avs.address];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      s1_d_q <= '0;
    end else if (!stall) begin
      s1_v_q <= rd_acc;
      if (rd_acc) s1_d_q <= rd_word;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_v_q;
      logic [DATA_WIDTH-1:0] s2_d_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s2_v_q <= 1'b0;
          s2_d_q <= '0;
        end else if (!stall) begin
          s2_v_q <= s1_v_q;
          if (s1_v_q) s2_d_q <= s1_d_q;
        end
      end

      assign out_v = s2_v_q;
      assign out_d = s2_d_q;
    end else begin : g_lat1
      assign out_v = s1_v_q;
      assign out_d = s1_d_q;
    end
  endgenerate

  // A strobe caught by a stall is held in the pipeline and shown once it ends.
  assign avs.readdatavalid = out_v & ~stall;
  assign avs.readdata      = out_d;

endmodule
